// File: rtl/vector_offload_queue.sv
// In-order offload FIFO between the core APU port and the vector decoder.
// Tracks issued IDs and returns completions to the core in order.
module vector_offload_queue #(
  parameter int DEPTH        = 4,
  parameter int X_ID_WIDTH   = 4,
  parameter int NUM_OPERANDS = 3,
  parameter int OP_WIDTH     = 6,
  parameter int FLAGS_WIDTH  = 15
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic                       apu_req,
  output logic                       apu_gnt,
  input  logic [NUM_OPERANDS*32-1:0] apu_operands_i,
  input  logic [OP_WIDTH-1:0]        apu_op,
  input  logic [FLAGS_WIDTH-1:0]     apu_flags_i,
  input  logic [X_ID_WIDTH-1:0]      offloaded_id_i,
  input  logic                       flush_i,
  output logic                       iss_valid_o,
  input  logic                       iss_ready_i,
  output logic [NUM_OPERANDS*32-1:0] iss_operands_o,
  output logic [OP_WIDTH-1:0]        iss_op_o,
  output logic [FLAGS_WIDTH-1:0]     iss_flags_o,
  output logic [X_ID_WIDTH-1:0]      iss_id_o,
  input  logic                       cpl_valid_i,
  input  logic [31:0]                cpl_result_i,
  input  logic [X_ID_WIDTH-1:0]      cpl_id_i,
  output logic                       apu_rvalid,
  output logic [31:0]                apu_result,
  output logic [X_ID_WIDTH-1:0]      instruction_id,
  output logic [$clog2(DEPTH):0]     queue_count_o,
  output logic [$clog2(DEPTH):0]     outstanding_o,
  output logic                       id_error_o,
  output logic                       busy_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int OPW = NUM_OPERANDS * 32;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [OPW-1:0]         opnd_mem  [DEPTH];
  logic [OP_WIDTH-1:0]    op_mem    [DEPTH];
  logic [FLAGS_WIDTH-1:0] flags_mem [DEPTH];
  logic [X_ID_WIDTH-1:0]  id_mem    [DEPTH];
  logic [X_ID_WIDTH-1:0]  idf_mem   [DEPTH];

  logic [AW-1:0]         head_q, head_d;
  logic [AW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         out_q, out_d;
  logic [AW-1:0]         idf_head_q, idf_head_d;
  logic [AW-1:0]         idf_tail_q, idf_tail_d;
  logic                  rvalid_q, rvalid_d;
  logic [31:0]           result_q, result_d;
  logic [X_ID_WIDTH-1:0] rid_q, rid_d;
  logic                  err_q, err_d;

  logic push, pop, cpl_ok, id_bad;

  assign apu_gnt     = (count_q != FULL) && !flush_i;
  assign iss_valid_o = (count_q != '0) && (out_q < FULL) && !flush_i;
  assign push        = apu_req && apu_gnt;
  assign pop         = iss_valid_o && iss_ready_i;
  assign cpl_ok      = cpl_valid_i && (out_q != '0);
  assign id_bad      = cpl_valid_i &&
                       (!cpl_ok || (cpl_id_i != idf_mem[idf_head_q]));

  assign iss_operands_o = opnd_mem[head_q];
  assign iss_op_o       = op_mem[head_q];
  assign iss_flags_o    = flags_mem[head_q];
  assign iss_id_o       = id_mem[head_q];

  assign apu_rvalid     = rvalid_q;
  assign apu_result     = result_q;
  assign instruction_id = rid_q;
  assign queue_count_o  = count_q;
  assign outstanding_o  = out_q;
  assign id_error_o     = err_q;
  assign busy_o         = (count_q != '0) || (out_q != '0);

  // Next state for pointers, counters and the registered result path.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    out_d      = out_q;
    idf_head_d = idf_head_q;
    idf_tail_d = idf_tail_q;
    rvalid_d   = cpl_ok;
    result_d   = result_q;
    rid_d      = rid_q;
    err_d      = err_q || id_bad;
    if (flush_i) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    unique case ({pop, cpl_ok})
      2'b10:   out_d = out_q + CW'(1);
      2'b01:   out_d = out_q - CW'(1);
      default: out_d = out_q;
    endcase
    if (pop)    idf_tail_d = idf_tail_q + AW'(1);
    if (cpl_ok) begin
      idf_head_d = idf_head_q + AW'(1);
      result_d   = cpl_result_i;
      rid_d      = cpl_id_i;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      out_q      <= '0;
      idf_head_q <= '0;
      idf_tail_q <= '0;
      rvalid_q   <= 1'b0;
      result_q   <= '0;
      rid_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      out_q      <= out_d;
      idf_head_q <= idf_head_d;
      idf_tail_q <= idf_tail_d;
      rvalid_q   <= rvalid_d;
      result_q   <= result_d;
      rid_q      <= rid_d;
      err_q      <= err_d;
    end
  end

  // Payload and issued-ID storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      opnd_mem[tail_q]  <= apu_operands_i;
      op_mem[tail_q]    <= apu_op;
      flags_mem[tail_q] <= apu_flags_i;
      id_mem[tail_q]    <= offloaded_id_i;
    end
    if (pop) idf_mem[idf_tail_q] <= iss_id_o;
  end

endmodule

// File: tb/tb_vector_offload_queue.sv
// Bench for vector_offload_queue: cycle vector table plus
// issue/completion scoreboards and a mid-stream reset sequence.
module tb_vector_offload_queue;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        apu_req;
  logic        apu_gnt;
  logic [95:0] apu_operands_i;
  logic [5:0]  apu_op;
  logic [14:0] apu_flags_i;
  logic [3:0]  offloaded_id_i;
  logic        flush_i;
  logic        iss_valid_o;
  logic        iss_ready_i;
  logic [95:0] iss_operands_o;
  logic [5:0]  iss_op_o;
  logic [14:0] iss_flags_o;
  logic [3:0]  iss_id_o;
  logic        cpl_valid_i;
  logic [31:0] cpl_result_i;
  logic [3:0]  cpl_id_i;
  logic        apu_rvalid;
  logic [31:0] apu_result;
  logic [3:0]  instruction_id;
  logic [2:0]  queue_count_o;
  logic [2:0]  outstanding_o;
  logic        id_error_o;
  logic        busy_o;

  vector_offload_queue #(
    .DEPTH(4), .X_ID_WIDTH(4), .NUM_OPERANDS(3),
    .OP_WIDTH(6), .FLAGS_WIDTH(15)
  ) dut (
    .clk(clk), .n_reset(n_reset),
    .apu_req(apu_req), .apu_gnt(apu_gnt),
    .apu_operands_i(apu_operands_i), .apu_op(apu_op),
    .apu_flags_i(apu_flags_i), .offloaded_id_i(offloaded_id_i),
    .flush_i(flush_i),
    .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
    .iss_operands_o(iss_operands_o), .iss_op_o(iss_op_o),
    .iss_flags_o(iss_flags_o), .iss_id_o(iss_id_o),
    .cpl_valid_i(cpl_valid_i), .cpl_result_i(cpl_result_i),
    .cpl_id_i(cpl_id_i),
    .apu_rvalid(apu_rvalid), .apu_result(apu_result),
    .instruction_id(instruction_id),
    .queue_count_o(queue_count_o), .outstanding_o(outstanding_o),
    .id_error_o(id_error_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          req;
    int          id;
    bit          rdy;
    bit          fl;
    bit          cv;
    logic [31:0] res;
    int          cid;
    bit          e_gnt;
    bit          e_iv;
    int          e_cnt;
    int          e_out;
    bit          e_rv;
    bit          e_err;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  id;
  } cpl_t;

  vec_t tbl[$];
  int   sb_iss[$];
  cpl_t sb_cpl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [5:0] op_of(input int id);
    return 6'(id + 2);
  endfunction

  function automatic logic [14:0] flags_of(input int id);
    return 15'(id * 7 + 256);
  endfunction

  function automatic logic [31:0] opnd_of(input int id, input int k);
    return 32'(32'h1000_0000 * (k + 1) + id);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic v(input bit req, input int id, input bit rdy,
                   input bit fl, input bit cv, input logic [31:0] res,
                   input int cid, input bit gnt, input bit iv,
                   input int cnt, input int out, input bit rv,
                   input bit err);
    vec_t t;
    t.req = req; t.id = id; t.rdy = rdy; t.fl = fl; t.cv = cv;
    t.res = res; t.cid = cid; t.e_gnt = gnt; t.e_iv = iv;
    t.e_cnt = cnt; t.e_out = out; t.e_rv = rv; t.e_err = err;
    tbl.push_back(t);
  endtask

  task automatic drive(input bit req, input int id, input bit rdy,
                       input bit fl, input bit cv,
                       input logic [31:0] res, input int cid);
    apu_req        = req;
    offloaded_id_i = 4'(id);
    apu_op         = op_of(id);
    apu_flags_i    = flags_of(id);
    for (int k = 0; k < 3; k++)
      apu_operands_i[32*k +: 32] = opnd_of(id, k);
    iss_ready_i    = rdy;
    flush_i        = fl;
    cpl_valid_i    = cv;
    cpl_result_i   = res;
    cpl_id_i       = 4'(cid);
  endtask

  // Scoreboard monitor: issued payloads and returned results.
  always @(negedge clk) begin
    if (n_reset) begin
      if (iss_valid_o && iss_ready_i) begin
        if (sb_iss.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL iss_extra: got id %0h expected none", iss_id_o);
        end else begin
          int id;
          id = sb_iss.pop_front();
          chk("iss_id", 32'(iss_id_o), 32'(id));
          chk("iss_op", 32'(iss_op_o), 32'(op_of(id)));
          chk("iss_flags", 32'(iss_flags_o), 32'(flags_of(id)));
          for (int k = 0; k < 3; k++)
            chk($sformatf("iss_opnd%0d", k),
                iss_operands_o[32*k +: 32], opnd_of(id, k));
        end
      end
      if (apu_rvalid) begin
        if (sb_cpl.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rvalid_extra: got result %0h expected none",
                   apu_result);
        end else begin
          cpl_t c;
          c = sb_cpl.pop_front();
          chk("cpl_result", apu_result, c.res);
          chk("cpl_id", 32'(instruction_id), 32'(c.id));
        end
      end
    end
  end

  initial begin
    n_reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    // req id rdy fl cv res cid | gnt iv cnt out rv err
    v(1,3,1,0,0,0,0,              1,0,0,0,0,0);
    v(0,0,1,0,0,0,0,              1,1,1,0,0,0);
    v(0,0,0,0,0,0,0,              1,0,0,1,0,0);
    v(0,0,0,0,1,32'h0000_0103,3,  1,0,0,1,0,0);
    v(0,0,0,0,0,0,0,              1,0,0,0,1,0);
    v(1,0,0,0,0,0,0,              1,0,0,0,0,0);
    v(1,1,0,0,0,0,0,              1,1,1,0,0,0);
    v(1,2,0,0,0,0,0,              1,1,2,0,0,0);
    v(1,3,0,0,0,0,0,              1,1,3,0,0,0);
    v(1,4,0,0,0,0,0,              0,1,4,0,0,0);
    v(1,4,1,0,0,0,0,              0,1,4,0,0,0);
    v(0,0,1,0,0,0,0,              1,1,3,1,0,0);
    v(0,0,1,0,0,0,0,              1,1,2,2,0,0);
    v(0,0,1,0,0,0,0,              1,1,1,3,0,0);
    v(0,0,1,0,1,32'hA0,0,         1,0,0,4,0,0);
    v(0,0,0,0,1,32'hA1,1,         1,0,0,3,1,0);
    v(0,0,0,0,1,32'hA2,2,         1,0,0,2,1,0);
    v(0,0,0,0,1,32'hA3,3,         1,0,0,1,1,0);
    v(0,0,0,0,0,0,0,              1,0,0,0,1,0);
    v(0,0,0,0,0,0,0,              1,0,0,0,0,0);
    v(1,5,0,0,0,0,0,              1,0,0,0,0,0);
    v(1,6,0,0,0,0,0,              1,1,1,0,0,0);
    v(1,7,1,0,0,0,0,              1,1,2,0,0,0);
    v(1,8,1,0,1,32'hC5,5,         1,1,2,1,0,0);
    v(1,9,1,0,1,32'hC6,6,         1,1,2,1,1,0);
    v(1,10,1,0,1,32'hC7,7,        1,1,2,1,1,0);
    v(1,11,1,0,1,32'hC8,8,        1,1,2,1,1,0);
    v(1,12,1,0,1,32'hC9,9,        1,1,2,1,1,0);
    v(0,0,1,0,1,32'hCA,10,        1,1,2,1,1,0);
    v(0,0,1,0,1,32'hCB,11,        1,1,1,1,1,0);
    v(0,0,1,0,1,32'hCC,12,        1,0,0,1,1,0);
    v(0,0,0,0,0,0,0,              1,0,0,0,1,0);
    v(1,0,1,0,0,0,0,              1,0,0,0,0,0);
    v(1,1,1,0,0,0,0,              1,1,1,0,0,0);
    v(1,2,1,0,0,0,0,              1,1,1,1,0,0);
    v(1,3,1,0,0,0,0,              1,1,1,2,0,0);
    v(1,4,1,0,0,0,0,              1,1,1,3,0,0);
    v(1,5,1,0,0,0,0,              1,0,1,4,0,0);
    v(0,0,1,0,1,32'hDEADBEEF,0,   1,0,2,4,0,0);
    v(0,0,1,0,0,0,0,              1,1,2,3,1,0);
    v(0,0,1,0,0,0,0,              1,0,1,4,0,0);
    v(0,0,1,0,1,32'hD1,1,         1,0,1,4,0,0);
    v(0,0,1,0,1,32'hD2,2,         1,1,1,3,1,0);
    v(0,0,1,0,1,32'hD3,3,         1,0,0,3,1,0);
    v(0,0,0,0,1,32'hD4,4,         1,0,0,2,1,0);
    v(0,0,0,0,1,32'hD5,5,         1,0,0,1,1,0);
    v(0,0,0,0,0,0,0,              1,0,0,0,1,0);
    v(1,2,1,0,0,0,0,              1,0,0,0,0,0);
    v(0,0,1,0,0,0,0,              1,1,1,0,0,0);
    v(0,0,0,0,1,32'h77,7,         1,0,0,1,0,0);
    v(0,0,0,0,0,0,0,              1,0,0,0,1,1);
    v(0,0,0,0,1,32'h99,9,         1,0,0,0,0,1);
    v(0,0,0,0,0,0,0,              1,0,0,0,0,1);
    v(1,1,1,0,0,0,0,              1,0,0,0,0,1);
    v(1,2,1,0,0,0,0,              1,1,1,0,0,1);
    v(1,3,0,0,0,0,0,              1,1,1,1,0,1);
    v(1,4,0,0,0,0,0,              1,1,2,1,0,1);
    v(1,5,1,1,0,0,0,              0,0,3,1,0,1);
    v(0,0,1,0,0,0,0,              1,0,0,1,0,1);
    v(0,0,0,0,1,32'hF1,1,         1,0,0,1,0,1);
    v(0,0,0,0,0,0,0,              1,0,0,0,1,1);
    v(0,0,0,0,0,0,0,              1,0,0,0,0,1);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", 32'(queue_count_o), 0);
    chk("rst_out", 32'(outstanding_o), 0);
    chk("rst_rvalid", 32'(apu_rvalid), 0);
    chk("rst_result", apu_result, 0);
    chk("rst_iid", 32'(instruction_id), 0);
    chk("rst_err", 32'(id_error_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_ivalid", 32'(iss_valid_o), 0);
    @(negedge clk);
    n_reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i].req, tbl[i].id, tbl[i].rdy, tbl[i].fl,
            tbl[i].cv, tbl[i].res, tbl[i].cid);
      if (tbl[i].fl) sb_iss.delete();
      if (tbl[i].req && tbl[i].e_gnt) sb_iss.push_back(tbl[i].id);
      if (tbl[i].cv && tbl[i].e_out > 0) begin
        cpl_t c;
        c.res = tbl[i].res;
        c.id  = 4'(tbl[i].cid);
        sb_cpl.push_back(c);
      end
      #1;
      chk($sformatf("v%0d_gnt", i), 32'(apu_gnt), 32'(tbl[i].e_gnt));
      chk($sformatf("v%0d_ivalid", i), 32'(iss_valid_o),
          32'(tbl[i].e_iv));
      chk($sformatf("v%0d_cnt", i), 32'(queue_count_o),
          32'(tbl[i].e_cnt));
      chk($sformatf("v%0d_out", i), 32'(outstanding_o),
          32'(tbl[i].e_out));
      chk($sformatf("v%0d_rvalid", i), 32'(apu_rvalid),
          32'(tbl[i].e_rv));
      chk($sformatf("v%0d_err", i), 32'(id_error_o), 32'(tbl[i].e_err));
      chk($sformatf("v%0d_busy", i), 32'(busy_o),
          32'(tbl[i].e_cnt != 0 || tbl[i].e_out != 0));
    end

    @(posedge clk);
    #1;
    chk("sb_iss_empty", 32'(sb_iss.size()), 0);
    chk("sb_cpl_empty", 32'(sb_cpl.size()), 0);

    // Mid-stream reset with a result pending and an entry queued.
    drive(1, 6, 1, 0, 0, 0, 0);
    sb_iss.push_back(6);
    @(posedge clk);
    #1;
    drive(0, 0, 1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    drive(1, 7, 0, 0, 1, 32'h6666, 6);
    sb_iss.push_back(7);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("pre_rvalid", 32'(apu_rvalid), 1);
    chk("pre_result", apu_result, 32'h6666);
    chk("pre_iid", 32'(instruction_id), 6);
    chk("pre_cnt", 32'(queue_count_o), 1);
    chk("pre_out", 32'(outstanding_o), 0);
    chk("pre_err", 32'(id_error_o), 1);
    #1;
    n_reset = 1'b0;
    sb_iss.delete();
    sb_cpl.delete();
    #1;
    chk("mid_cnt", 32'(queue_count_o), 0);
    chk("mid_out", 32'(outstanding_o), 0);
    chk("mid_rvalid", 32'(apu_rvalid), 0);
    chk("mid_result", apu_result, 0);
    chk("mid_iid", 32'(instruction_id), 0);
    chk("mid_err", 32'(id_error_o), 0);
    chk("mid_busy", 32'(busy_o), 0);
    chk("mid_ivalid", 32'(iss_valid_o), 0);
    @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_gnt", 32'(apu_gnt), 1);
    chk("post_cnt", 32'(queue_count_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
